// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 Set-2 scancode decoder: FSM states,
// prefix/control byte values, modifier scancodes and byte classifiers.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } ps2_state_e;

    localparam logic [7:0] PFX_E0 = 8'hE0;
    localparam logic [7:0] PFX_F0 = 8'hF0;
    localparam logic [7:0] PFX_E1 = 8'hE1;

    localparam logic [7:0] CTL_AA = 8'hAA;
    localparam logic [7:0] CTL_FA = 8'hFA;
    localparam logic [7:0] CTL_EE = 8'hEE;
    localparam logic [7:0] CTL_FE = 8'hFE;
    localparam logic [7:0] CTL_00 = 8'h00;
    localparam logic [7:0] CTL_FF = 8'hFF;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;

    // Bit positions in the held-modifier flag vector (left/right tracked apart).
    localparam int FL_LSHIFT = 0;
    localparam int FL_RSHIFT = 1;
    localparam int FL_LCTRL  = 2;
    localparam int FL_RCTRL  = 3;
    localparam int FL_LALT   = 4;
    localparam int FL_RALT   = 5;
    localparam int FL_W      = 6;

    function automatic logic is_ctrl_byte(input logic [7:0] b);
        case (b)
            CTL_AA, CTL_FA, CTL_EE, CTL_FE, CTL_00, CTL_FF: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    function automatic logic is_brk_prefix(input logic [7:0] b);
        return (b == PFX_E0) || (b == PFX_F0);
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a one-cycle
// rising-edge indication taken on the synchronized side.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronizer chain and delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign rise = sync_r & ~prev_r;

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Turns the PS/2 receiver's byte stream into single make/break key events,
// device control strobes and error strobes, and tracks held modifiers.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT   = 1_000_000,
    parameter int PAUSE_LEN = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       rx_error,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       ctrl_valid,
    output logic [7:0] ctrl_code,
    output logic       err_pulse,
    output logic       mod_shift,
    output logic       mod_ctrl,
    output logic       mod_alt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = $clog2(PAUSE_LEN + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    ps2_state_e        state_r, state_n;
    logic [PW-1:0]     pause_r, pause_n;
    logic [TW-1:0]     tmo_r;
    logic [FL_W-1:0]   flags_r, flags_n;
    logic              err_meta_r, err_sync_r;
    logic              accept_s, tmo_fire_s;
    logic              emit_s, ev_ext_s, ev_rel_s;
    logic [7:0]        ev_code_s;
    logic              key_valid_r, key_ext_r, key_release_r, ctrl_valid_r, err_pulse_r;
    logic [7:0]        key_code_r, ctrl_code_r;
    logic              mod_shift_r, mod_ctrl_r, mod_alt_r;
    logic              kv_n, ext_n, rel_n, cv_n, err_n;
    logic [7:0]        code_n, ccode_n;

    ps2_sync_edge u_ready_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (rx_ready),
        .rise (accept_s)
    );

    // rx_error only needs to be level-synchronized alongside rx_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_meta_r <= 1'b0;
            err_sync_r <= 1'b0;
        end else begin
            err_meta_r <= rx_error;
            err_sync_r <= err_meta_r;
        end
    end

    // Next-state, event and modifier decode for the accepted byte or timeout.
    always_comb begin
        state_n    = state_r;
        pause_n    = pause_r;
        flags_n    = flags_r;
        kv_n       = 1'b0;
        cv_n       = 1'b0;
        err_n      = 1'b0;
        code_n     = key_code_r;
        ext_n      = key_ext_r;
        rel_n      = key_release_r;
        ccode_n    = ctrl_code_r;
        emit_s     = 1'b0;
        ev_code_s  = rx_data;
        ev_ext_s   = 1'b0;
        ev_rel_s   = 1'b0;
        tmo_fire_s = 1'b0;
        if (accept_s && err_sync_r) begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
        end else if (accept_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_data == PFX_E0) begin
                        state_n = ST_EXT;
                    end else if (rx_data == PFX_F0) begin
                        state_n = ST_BRK;
                    end else if (rx_data == PFX_E1) begin
                        state_n = ST_PAUSE;
                        pause_n = PW'(PAUSE_LEN);
                    end else if (is_ctrl_byte(rx_data)) begin
                        cv_n    = 1'b1;
                        ccode_n = rx_data;
                        flags_n = (rx_data == CTL_AA) ? '0 : flags_r;
                    end else begin
                        emit_s = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (rx_data == PFX_F0) begin
                        state_n = ST_EXT_BRK;
                    end else if (rx_data == PFX_E0) begin
                        state_n = ST_EXT;
                    end else begin
                        emit_s   = 1'b1;
                        ev_ext_s = 1'b1;
                        state_n  = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    state_n = ST_IDLE;
                    if (is_brk_prefix(rx_data)) begin
                        err_n = 1'b1;
                    end else begin
                        emit_s   = 1'b1;
                        ev_ext_s = (state_r == ST_EXT_BRK);
                        ev_rel_s = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    pause_n = pause_r - PW'(1);
                    if (pause_r <= PW'(1)) begin
                        emit_s    = 1'b1;
                        ev_code_s = PFX_E1;
                        state_n   = ST_IDLE;
                    end else begin
                        state_n = ST_PAUSE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end else if ((state_r != ST_IDLE) && (tmo_r == TMO_LAST)) begin
            tmo_fire_s = 1'b1;
            err_n      = 1'b1;
            state_n    = ST_IDLE;
        end else begin
            state_n = state_r;
        end
        if (emit_s) begin
            kv_n   = 1'b1;
            code_n = ev_code_s;
            ext_n  = ev_ext_s;
            rel_n  = ev_rel_s;
            flags_n[FL_LSHIFT] = (ev_code_s == SC_LSHIFT && !ev_ext_s) ? ~ev_rel_s : flags_r[FL_LSHIFT];
            flags_n[FL_RSHIFT] = (ev_code_s == SC_RSHIFT && !ev_ext_s) ? ~ev_rel_s : flags_r[FL_RSHIFT];
            flags_n[FL_LCTRL]  = (ev_code_s == SC_CTRL && !ev_ext_s)   ? ~ev_rel_s : flags_r[FL_LCTRL];
            flags_n[FL_RCTRL]  = (ev_code_s == SC_CTRL && ev_ext_s)    ? ~ev_rel_s : flags_r[FL_RCTRL];
            flags_n[FL_LALT]   = (ev_code_s == SC_ALT && !ev_ext_s)    ? ~ev_rel_s : flags_r[FL_LALT];
            flags_n[FL_RALT]   = (ev_code_s == SC_ALT && ev_ext_s)     ? ~ev_rel_s : flags_r[FL_RALT];
        end else begin
            kv_n = 1'b0;
        end
    end

    // State, pause count, flags and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            pause_r       <= '0;
            flags_r       <= '0;
            key_valid_r   <= 1'b0;
            key_code_r    <= 8'h00;
            key_ext_r     <= 1'b0;
            key_release_r <= 1'b0;
            ctrl_valid_r  <= 1'b0;
            ctrl_code_r   <= 8'h00;
            err_pulse_r   <= 1'b0;
            mod_shift_r   <= 1'b0;
            mod_ctrl_r    <= 1'b0;
            mod_alt_r     <= 1'b0;
        end else begin
            state_r       <= state_n;
            pause_r       <= pause_n;
            flags_r       <= flags_n;
            key_valid_r   <= kv_n;
            key_code_r    <= code_n;
            key_ext_r     <= ext_n;
            key_release_r <= rel_n;
            ctrl_valid_r  <= cv_n;
            ctrl_code_r   <= ccode_n;
            err_pulse_r   <= err_n;
            mod_shift_r   <= flags_n[FL_LSHIFT] | flags_n[FL_RSHIFT];
            mod_ctrl_r    <= flags_n[FL_LCTRL] | flags_n[FL_RCTRL];
            mod_alt_r     <= flags_n[FL_LALT] | flags_n[FL_RALT];
        end
    end

    // Prefix timeout: counts only while waiting mid-sequence, restarts per byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_r <= '0;
        end else if (accept_s || (state_r == ST_IDLE) || tmo_fire_s) begin
            tmo_r <= '0;
        end else begin
            tmo_r <= tmo_r + TW'(1);
        end
    end

    assign key_valid   = key_valid_r;
    assign key_code    = key_code_r;
    assign key_ext     = key_ext_r;
    assign key_release = key_release_r;
    assign ctrl_valid  = ctrl_valid_r;
    assign ctrl_code   = ctrl_code_r;
    assign err_pulse   = err_pulse_r;
    assign mod_shift   = mod_shift_r;
    assign mod_ctrl    = mod_ctrl_r;
    assign mod_alt     = mod_alt_r;

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Downstream consumer of the PS/2 byte receiver: takes its byte/ready/error outputs and converts Set-2 scancode byte streams into single key events.
- Handles the E0 (extended), F0 (break) and E1 (pause) prefixes and device control bytes.
- Tracks live modifier state.
- Sits between the PS/2 receiver and the keyboard-to-ASCII/application logic, all in the system clk domain.

Parameters:
- TIMEOUT, 1_000_000, number of clk cycles a pending prefix may wait for its next byte before being discarded.
- PAUSE_LEN, 7, number of bytes discarded after E1 (the E1 14 77 E1 F0 14 F0 77 sequence).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- rx_data  input  8  received byte from the PS/2 receiver; stable while rx_ready is high.
- rx_ready  input  1  receiver frame-complete level; asynchronous to clk.
- rx_error  input  1  receiver error flag, valid while rx_ready is high; asynchronous to clk.
- key_valid  output  1  one-cycle event strobe.
- key_code  output  8  base scancode of the event; 8'hE1 for pause.
- key_ext  output  1  event carried the E0 prefix.
- key_release  output  1  event carried the F0 prefix (break).
- ctrl_valid  output  1  one-cycle strobe for a device control byte.
- ctrl_code  output  8  control byte: AA, FA, EE, FE, 00 or FF.
- err_pulse  output  1  one-cycle strobe: framing error or prefix timeout.
- mod_shift, mod_ctrl, mod_alt  output  1 each  modifier currently held.

Behaviour:
- Reset (rst=1 at a clk edge, overrides everything):
  - All outputs 0.
  - FSM to IDLE; synchronizers to 0; timeout counter 0; pause counter 0.
- Input sync:
  - rx_ready and rx_error each pass through a 2-flop synchronizer.
  - A byte is accepted in cycle A, the first cycle where synced ready=1 and its previous value=0.
  - rx_data is sampled directly in cycle A.
- Latency: all strobes (key_valid, ctrl_valid, err_pulse) assert in cycle A+1 for exactly 1 cycle. Data outputs are updated in the same cycle and held until the next strobe.
- Error byte (synced rx_error=1 at A): byte discarded, err_pulse, FSM to IDLE, prefix flags cleared.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), PAUSE.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE with pause counter = PAUSE_LEN.
  - AA/FA/EE/FE/00/FF -> ctrl_valid, ctrl_code = byte; stay IDLE.
  - Any other byte -> make event: key_valid, ext=0, release=0.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay.
  - Any other byte -> event with ext=1, release=0; to IDLE.
- BRK: any byte other than E0/F0 -> event with ext=0, release=1; to IDLE. An E0 or F0 byte -> err_pulse, to IDLE.
- EXT_BRK: non-prefix byte -> event with ext=1, release=1; to IDLE. Prefix byte -> err_pulse, to IDLE.
- PAUSE:
  - Each accepted byte decrements the pause counter; byte values are ignored.
  - On the byte where the counter reaches 0: key_valid, key_code=E1, ext=0, release=0; to IDLE.
- Timeout:
  - The timeout counter runs only in EXT/BRK/EXT_BRK/PAUSE and resets on each accepted byte.
  - Reaching TIMEOUT-1: err_pulse, FSM to IDLE.
  - If a byte is accepted in the same cycle, the byte wins and is processed in the current state.
- Modifiers, updated in the same cycle as key_valid:
  - mod_shift = left Shift (12, non-ext) held OR right Shift (59, non-ext) held.
  - mod_ctrl = 14 held (ext or non-ext).
  - mod_alt = 11 held (ext or non-ext).
  - Left and right keys are tracked in separate flags. Make sets the flag, break clears it.
  - Modifier flags are unaffected by errors; they clear only on rst or on a received AA.
- Events are emitted regardless of key_code value; no filtering of unknown codes.

Decomposition:
- Shared package ps2_pkg:
  - FSM state enum.
  - Prefix constants E0, F0, E1.
  - Control-byte constants AA, FA, EE, FE, 00, FF.
  - Modifier scancodes 12, 59, 14, 11.
- One sub-module: ps2_sync_edge (2-flop synchronizer plus rising-edge detect), instantiated for rx_ready. rx_error uses its synchronizer path only.

Test Plan:
1. Send byte 1C (err=0) -> one key_valid, key_code=1C, ext=0, release=0; asserted 1 cycle, in cycle A+1.
2. Send E0 F0 75 -> single key_valid with code=75, ext=1, release=1; no strobes on the prefix bytes.
3. Send 12, then 1C, then F0 12 -> mod_shift=1 in the cycle of the first event and through the 1C event; mod_shift=0 after the break.
4. Send E0 with TIMEOUT=16, no further bytes -> err_pulse 16 cycles later, state IDLE; a following 1C yields ext=0.
5. Send E1 followed by 7 pause bytes -> exactly one key_valid, code=E1; send a byte with rx_error=1 -> err_pulse, no key_valid.
6. Send AA -> ctrl_valid with ctrl_code=AA and all modifiers cleared; assert rst after an E0 -> all outputs 0, next byte 1C decodes as non-extended.
